dir_input_ctrl: RTL and testbench

- Parametrised direction-input front end replacing the combinational button-to-rotate encoding between the board buttons and game_state.
- Per channel (player): synchronises and debounces four direction buttons, detects presses, filters same/reverse turns, and queues accepted turns.
- Releases one queued turn per game tick, so fast double-taps between ticks are not lost.
- Runs in the 65 MHz pixel clock domain.

---
 rtl/dir_input_ctrl_if.sv | 20 ++
 rtl/dir_input_ctrl.sv | 160 ++++++++++++++++
 tb/tb_dir_input_ctrl.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/dir_input_ctrl_if.sv
// Button/tick inputs and direction/queue status outputs of dir_input_ctrl.
// The top drives the slave side; the board glue or a bench drives the master side.
interface dir_input_ctrl_if #(
  parameter int NUM_CH      = 1,
  parameter int QUEUE_DEPTH = 2
);
  localparam int CW = $clog2(QUEUE_DEPTH + 1);

  logic [4*NUM_CH-1:0]  btn_in;
  logic                 tick_in;
  logic [2*NUM_CH-1:0]  dir_out;
  logic [NUM_CH-1:0]    dir_valid;
  logic [NUM_CH*CW-1:0] q_count;
  logic [NUM_CH-1:0]    overflow;

  modport master (output btn_in, tick_in,
                  input  dir_out, dir_valid, q_count, overflow);
  modport slave  (input  btn_in, tick_in,
                  output dir_out, dir_valid, q_count, overflow);
endinterface

// File: rtl/dir_input_ctrl.sv
// Per-player direction front end: sync, debounce, press detect, turn filter, turn FIFO.
// Macro DIR_REVERSE_BLOCK_EN: when defined, 180-degree turns are rejected as well.
module dir_input_ch #(
  parameter int         SYNC_STAGES     = 2,
  parameter int         DEBOUNCE_CYCLES = 650000,
  parameter int         QUEUE_DEPTH     = 2,
  parameter logic [1:0] INIT_DIR        = 2'b10,
  parameter int         CW              = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [3:0]    i_btn,
  input  logic          i_tick,
  output logic [1:0]    o_dir,
  output logic          o_dir_valid,
  output logic [CW-1:0] o_q_count,
  output logic          o_overflow
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int PW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [PW-1:0] PTR_LAST = PW'(QUEUE_DEPTH - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(QUEUE_DEPTH);

  logic [SYNC_STAGES-1:0][3:0] r_sync;
  logic [3:0][DW-1:0]          r_db_cnt;
  logic [3:0]                  r_deb, r_deb_q, r_press;
  logic [3:0]                  w_synced;

  logic [QUEUE_DEPTH-1:0][1:0] r_mem;
  logic [PW-1:0]               r_wr, r_rd;
  logic [CW-1:0]               r_count;
  logic [1:0]                  r_dir;
  logic                        r_dv, r_ovf;

  logic [1:0]    w_cand, w_ref;
  logic [PW-1:0] w_tail;
  logic          w_cand_vld, w_rev, w_push_req, w_full, w_pop, w_push, w_drop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst) r_sync <= '0;
    else      r_sync <= {r_sync[SYNC_STAGES-2:0], i_btn};
  end
  assign w_synced = r_sync[SYNC_STAGES-1];

  // Level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_db_cnt <= '0;
      r_deb    <= '0;
      r_deb_q  <= '0;
      r_press  <= '0;
    end else begin
      for (int b = 0; b < 4; b++) begin
        if (w_synced[b] == r_deb[b]) begin
          r_db_cnt[b] <= '0;
        end else if (r_db_cnt[b] == DB_LAST) begin
          r_deb[b]    <= w_synced[b];
          r_db_cnt[b] <= '0;
        end else begin
          r_db_cnt[b] <= r_db_cnt[b] + 1'b1;
        end
      end
      r_deb_q <= r_deb;
      r_press <= r_deb & ~r_deb_q;
    end
  end

  // Bit index {left,right,down,up} doubles as the direction code.
  always_comb begin
    w_cand_vld = |r_press;
    w_cand     = 2'b00;
    if (r_press[3])      w_cand = 2'b11;
    else if (r_press[2]) w_cand = 2'b10;
    else if (r_press[1]) w_cand = 2'b01;
  end

  assign w_tail = (r_wr == '0) ? PTR_LAST : r_wr - 1'b1;
  assign w_ref  = (r_count != '0) ? r_mem[w_tail] : r_dir;

`ifdef DIR_REVERSE_BLOCK_EN
  assign w_rev = (w_cand == (w_ref ^ 2'b01));
`else
  assign w_rev = 1'b0;
`endif

  assign w_push_req = w_cand_vld && (w_cand != w_ref) && !w_rev;
  assign w_full     = (r_count == CNT_FULL);
  assign w_pop      = i_tick && (r_count != '0);
  // A pop in the same cycle frees the slot, so a full queue still accepts.
  assign w_push     = w_push_req && (!w_full || w_pop);
  assign w_drop     = w_push_req && w_full && !w_pop;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_mem   <= '0;
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
      r_dir   <= INIT_DIR;
      r_dv    <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_dv <= w_pop;
      if (w_pop) begin
        r_dir <= r_mem[r_rd];
        r_rd  <= ptr_inc(r_rd);
      end
      if (w_push) begin
        r_mem[r_wr] <= w_cand;
        r_wr        <= ptr_inc(r_wr);
      end
      if (w_drop) r_ovf <= 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (w_pop && !w_push) r_count <= r_count - 1'b1;
    end
  end

  assign o_dir       = r_dir;
  assign o_dir_valid = r_dv;
  assign o_q_count   = r_count;
  assign o_overflow  = r_ovf;
endmodule

module dir_input_ctrl #(
  parameter int         NUM_CH          = 1,
  parameter int         SYNC_STAGES     = 2,
  parameter int         DEBOUNCE_CYCLES = 650000,
  parameter int         QUEUE_DEPTH     = 2,
  parameter logic [1:0] INIT_DIR        = 2'b10
) (
  input  logic          clk,
  input  logic          rst,
  dir_input_ctrl_if.slave bus
);
  localparam int CW = $clog2(QUEUE_DEPTH + 1);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    dir_input_ch #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .QUEUE_DEPTH    (QUEUE_DEPTH),
      .INIT_DIR       (INIT_DIR),
      .CW             (CW)
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .i_btn      (bus.btn_in[4*c +: 4]),
      .i_tick     (bus.tick_in),
      .o_dir      (bus.dir_out[2*c +: 2]),
      .o_dir_valid(bus.dir_valid[c]),
      .o_q_count  (bus.q_count[CW*c +: CW]),
      .o_overflow (bus.overflow[c])
    );
  end
endmodule

// File: tb/tb_dir_input_ctrl.sv
// Directed bench for dir_input_ctrl (2 channels, 2 sync stages, 4-cycle debounce, depth 2).
// Expected directions are queued per channel and popped whenever dir_valid pulses.
module tb_dir_input_ctrl;
  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [1:0] exp0[$];
  logic [1:0] exp1[$];

  always #5 clk = ~clk;

  dir_input_ctrl_if #(.NUM_CH(2), .QUEUE_DEPTH(2)) bus ();

  dir_input_ctrl #(
    .NUM_CH(2), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .QUEUE_DEPTH(2), .INIT_DIR(2'b10)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_btn(input int c, input logic [3:0] b);
    bus.btn_in[4*c +: 4] = b;
  endtask

  // Press held long enough to be pushed, then released and settled.
  task automatic tap(input int c, input logic [3:0] b);
    set_btn(c, b);
    step(8);
    set_btn(c, 4'b0000);
    step(8);
  endtask

  task automatic do_tick();
    bus.tick_in = 1'b1;
    step(1);
    bus.tick_in = 1'b0;
    step(1);
  endtask

  // Scoreboard: every dir_valid pulse must match the oldest expected turn.
  always @(negedge clk) begin
    if (rst) begin
      if (bus.dir_valid[0]) begin
        if (exp0.size() == 0) begin
          n_tests++; n_fail++;
          $error("FAIL sb0_unexpected: observed dir %0h expected no pulse", bus.dir_out[1:0]);
        end else chk("sb0_dir", 32'(bus.dir_out[1:0]), 32'(exp0.pop_front()));
      end
      if (bus.dir_valid[1]) begin
        if (exp1.size() == 0) begin
          n_tests++; n_fail++;
          $error("FAIL sb1_unexpected: observed dir %0h expected no pulse", bus.dir_out[3:2]);
        end else chk("sb1_dir", 32'(bus.dir_out[3:2]), 32'(exp1.pop_front()));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, observed hang expected $finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0;
    bus.tick_in = 1'b0;
    bus.btn_in  = 8'hFF;
    step(3);
    rst = 1'b1;
    bus.btn_in = 8'h00;
    chk("rst_dir", bus.dir_out, 4'b1010);
    chk("rst_dv",  bus.dir_valid, 0);
    chk("rst_q",   bus.q_count, 0);
    chk("rst_ovf", bus.overflow, 0);

    // Latency: up on ch0 held from cycle t
    set_btn(0, 4'b0001);
    exp0.push_back(2'b00);
    step(7); chk("lat_q0_t7", bus.q_count[1:0], 0);
    step(1); chk("lat_q0_t8", bus.q_count[1:0], 1);
    chk("lat_q1_idle", bus.q_count[3:2], 0);
    set_btn(0, 4'b0000);
    step(2);
    bus.tick_in = 1'b1;
    step(1);
    bus.tick_in = 1'b0;
    chk("tick_dv",  bus.dir_valid, 2'b01);
    chk("tick_dir", bus.dir_out, 4'b1000);
    step(1);
    chk("tick_dv_off", bus.dir_valid, 0);
    chk("tick_q0", bus.q_count[1:0], 0);
    step(8);

    // Glitch and bounce on ch1 down
    set_btn(1, 4'b0010); step(3); set_btn(1, 4'b0000); step(10);
    chk("glitch_q1", bus.q_count[3:2], 0);
    set_btn(1, 4'b0010); step(1);
    set_btn(1, 4'b0000); step(1);
    set_btn(1, 4'b0010); step(12);
    chk("bounce_q1", bus.q_count[3:2], 1);
    exp1.push_back(2'b01);
    set_btn(1, 4'b0000); step(8);
    do_tick();
    chk("bounce_dir1", bus.dir_out[3:2], 2'b01);
    chk("bounce_q1_empty", bus.q_count[3:2], 0);

    // Same-cycle up+left on ch0: left wins
    set_btn(0, 4'b1001); step(8);
    chk("arb_q0", bus.q_count[1:0], 1);
    exp0.push_back(2'b11);
    set_btn(0, 4'b0000); step(8);
    do_tick();
    chk("arb_dir0", bus.dir_out[1:0], 2'b11);

    // ch1 right accepted, then right again rejected as same direction
    tap(1, 4'b0100);
    exp1.push_back(2'b10);
    chk("right_q1", bus.q_count[3:2], 1);
    do_tick();
    chk("right_dir1", bus.dir_out[3:2], 2'b10);
    tap(1, 4'b0100);
    chk("same_q1", bus.q_count[3:2], 0);

    // Reverse against dir_out, then reverse against queue tail
    tap(1, 4'b1000);
`ifdef DIR_REVERSE_BLOCK_EN
    chk("rev_q1", bus.q_count[3:2], 0);
`else
    chk("rev_q1", bus.q_count[3:2], 1);
    exp1.push_back(2'b11);
`endif
    do_tick();
    tap(1, 4'b0001);
    exp1.push_back(2'b00);
    chk("up_q1", bus.q_count[3:2], 1);
    tap(1, 4'b0010);
`ifdef DIR_REVERSE_BLOCK_EN
    chk("rev_tail_q1", bus.q_count[3:2], 1);
`else
    chk("rev_tail_q1", bus.q_count[3:2], 2);
    exp1.push_back(2'b01);
`endif
    do_tick();
    do_tick();
    chk("drain_q1", bus.q_count[3:2], 0);
`ifdef DIR_REVERSE_BLOCK_EN
    chk("drain_dir1", bus.dir_out[3:2], 2'b00);
`else
    chk("drain_dir1", bus.dir_out[3:2], 2'b01);
`endif

    // Overflow on ch0 (dir 11): up, left fill; down is dropped
    tap(0, 4'b0001); exp0.push_back(2'b00);
    tap(0, 4'b1000); exp0.push_back(2'b11);
    chk("fill_q0", bus.q_count[1:0], 2);
    chk("fill_ovf", bus.overflow, 0);
    tap(0, 4'b0010);
    chk("ovf_q0", bus.q_count[1:0], 2);
    chk("ovf_flag", bus.overflow, 2'b01);

    // Tick at full coincident with an accepted push
    set_btn(0, 4'b0010);
    step(7);
    bus.tick_in = 1'b1;
    exp0.push_back(2'b01);
    step(1);
    bus.tick_in = 1'b0;
    chk("pp_q0", bus.q_count[1:0], 2);
    chk("pp_ovf", bus.overflow, 2'b01);
    chk("pp_dir0", bus.dir_out[1:0], 2'b00);
    set_btn(0, 4'b0000); step(8);
    do_tick();
    do_tick();
    chk("pp_drain_q0", bus.q_count[1:0], 0);
    chk("pp_drain_dir0", bus.dir_out[1:0], 2'b01);

    // Reset mid-operation discards a queued turn and a partial debounce
    tap(0, 4'b1000);
    chk("mid_q0", bus.q_count[1:0], 1);
    set_btn(1, 4'b0100);
    step(3);
    rst = 1'b0;
    step(2);
    rst = 1'b1;
    set_btn(1, 4'b0000);
    chk("mid_rst_dir", bus.dir_out, 4'b1010);
    chk("mid_rst_q", bus.q_count, 0);
    chk("mid_rst_ovf", bus.overflow, 0);
    chk("mid_rst_dv", bus.dir_valid, 0);
    step(12);
    chk("mid_rst_q_idle", bus.q_count, 0);
    chk("sb0_drained", exp0.size(), 0);
    chk("sb1_drained", exp1.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
